vga_axis_pattern_gen: RTL and testbench
=======================================

VGA_AXIS_PATTERN_GEN -- requirements
Module: vga_axis_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-003 SHALL have parameter BAR_STEP, default 8, moving-bar advance in pixels per frame.
REQ-004 SHALL have port axi_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port axi_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  run request.
REQ-007 SHALL have port mode  input  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 moving bar.
REQ-008 SHALL have port m_axis_tdata  output  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}.
REQ-009 SHALL have port m_axis_tuser  output  1  start of frame.
REQ-010 SHALL have port m_axis_tlast  output  1  end of line.
REQ-011 SHALL have port m_axis_tvalid  output  1  pixel valid.
REQ-012 SHALL have port m_axis_tready  input  1  downstream accept.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse per completed frame.
REQ-014 SHALL have port frame_count  output  8  completed frames, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE and STREAM; reset state IDLE.
REQ-016 IDLE: tvalid=0; on enable=1, SHALL latch mode into mode_q, clear x/y, and enter STREAM next cycle.
REQ-017 STREAM: tvalid SHALL be 1 continuously; a beat transfers only when tvalid&&tready.
REQ-018 tdata/tuser/tlast SHALL depend only on registered state (x, y, mode_q, bar_pos), never on tready, and SHALL stay stable while tvalid&&!tready.
REQ-019 x SHALL increment on transfer; at x=H_ACTIVE-1 it wraps to 0 and y increments; at y=V_ACTIVE-1 with x=H_ACTIVE-1 the frame ends.
REQ-020 tuser SHALL be 1 only at (x=0,y=0); tlast SHALL be 1 only at x=H_ACTIVE-1.
REQ-021 On end-of-frame transfer: frame_count increments, frame_done pulses the following cycle, bar_pos advances by BAR_STEP (if the sum >= H_ACTIVE, subtract H_ACTIVE).
REQ-022 On end-of-frame transfer: if enable=1, relatch mode and stay in STREAM with x=y=0 (no gap cycle); else go to IDLE.
REQ-023 enable deassertion or mode change mid-frame SHALL NOT affect the current frame; frames are never truncated.
REQ-024 Mode 0: eight bars of width H_ACTIVE/8, left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; pixels beyond 8*(H_ACTIVE/8) are 0000.
REQ-025 Mode 1: R=x[7:3], G=y[7:2], B=~x[7:3].
REQ-026 Mode 2: FFFF when x[5]^y[5]=1, else 0000.
REQ-027 Mode 3: FFFF when bar_pos <= x < bar_pos+16 (clipped at H_ACTIVE, no wrap), else 001F.
REQ-028 x and y SHALL be sized $clog2(H_ACTIVE) and $clog2(V_ACTIVE) bits; compares are unsigned.

Reset
REQ-029 On axi_rstn=0, asynchronously: state=IDLE, tvalid=0, tuser=0, tlast=0, tdata=0000, frame_done=0, frame_count=0, x=y=0, bar_pos=0, mode_q=0.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, streaming restarts at (0,0) with tuser=1.

Verification
REQ-031 H_ACTIVE=16, V_ACTIVE=4, mode=0, enable=1, tready=1 -> 64 beats; tuser on beat 0 only; tlast on beats 15,31,47,63; tdata pairs FFFF,FFFF,FFE0,FFE0,...,0000,0000; frame_done pulse one cycle after beat 63; frame_count=1.
REQ-032 Random tready backpressure (50%) -> no beat lost or duplicated; tdata/tuser/tlast unchanged while tvalid&&!tready; 64 transfers per frame.
REQ-033 enable dropped at beat 10 -> frame completes all 64 beats, then tvalid=0 and state IDLE; mode changed at beat 20 -> takes effect only at next frame's beat 0.
REQ-034 Mode 3, BAR_STEP=8, H_ACTIVE=16 -> bar_pos 0,8,0,8 over four frames; frame 1 row pixels 8..15 FFFF, 0..7 001F.
REQ-035 axi_rstn pulsed low at beat 30 -> outputs at reset values immediately; after release with enable=1, first beat has tuser=1, frame_count=0.
REQ-036 300 back-to-back frames -> frame_count wraps 255->0; no idle cycle between frames.

Source files
------------

// File: rtl/vga_axis_pattern_gen.sv
// vga_axis_pattern_gen: AXI4-Stream video test-pattern source.
// Emits RGB565 frames of H_ACTIVE x V_ACTIVE pixels. tuser marks the start of a
// frame and tlast marks the end of each line. Four patterns are available:
// colour bars, gradient, checkerboard and a bar that moves from frame to frame.
module vga_axis_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int BAR_STEP = 8
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W > 0) ? BAR_W : 1;
  localparam int MOVE_W  = 16;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, nxt_state;
  logic [XW-1:0] x, nxt_x;
  logic [YW-1:0] y, nxt_y;
  logic [XW-1:0] bar_pos, nxt_bar;
  logic [1:0]    mode_q, nxt_mode;
  logic          xfer, eol, eof;
  logic [31:0]   bar_sum;

  // Pixel colour for one coordinate. All operands are widened to 32 bits so
  // the bit fields used by the gradient/checker exist for any frame size.
  function automatic logic [15:0] pixel(input logic [XW-1:0] px,
                                        input logic [YW-1:0] py,
                                        input logic [1:0]    pm,
                                        input logic [XW-1:0] pb);
    logic [31:0] xe, ye, be, idx;
    logic [4:0]  r;
    logic [5:0]  g;
    xe    = 32'(px);
    ye    = 32'(py);
    be    = 32'(pb);
    idx   = 32'd0;
    r     = 5'd0;
    g     = 6'd0;
    pixel = 16'h0000;
    case (pm)
      2'd0: begin
        idx = xe / 32'(BAR_DIV);
        case (idx)
          32'd0:   pixel = 16'hFFFF;
          32'd1:   pixel = 16'hFFE0;
          32'd2:   pixel = 16'h07FF;
          32'd3:   pixel = 16'h07E0;
          32'd4:   pixel = 16'hF81F;
          32'd5:   pixel = 16'hF800;
          32'd6:   pixel = 16'h001F;
          default: pixel = 16'h0000;  // last bar and any leftover columns
        endcase
      end
      2'd1: begin
        r     = 5'(xe >> 3);
        g     = 6'(ye >> 2);
        pixel = {r, g, ~r};
      end
      2'd2: begin
        pixel = ((((xe ^ ye) >> 5) & 32'd1) != 32'd0) ? 16'hFFFF : 16'h0000;
      end
      default: begin
        // Window is clipped at the right edge simply because x never reaches H_ACTIVE.
        pixel = (xe >= be && xe < be + 32'(MOVE_W)) ? 16'hFFFF : 16'h001F;
      end
    endcase
  endfunction

  // Next-state logic: raster position, mode latch and moving-bar position.
  always_comb begin
    nxt_state = state;
    nxt_x     = x;
    nxt_y     = y;
    nxt_bar   = bar_pos;
    nxt_mode  = mode_q;
    xfer      = (state == STREAM) && m_axis_tready;
    eol       = (x == XW'(H_ACTIVE - 1));
    eof       = eol && (y == YW'(V_ACTIVE - 1));
    bar_sum   = 32'(bar_pos) + 32'(BAR_STEP);
    if (bar_sum >= 32'(H_ACTIVE)) begin
      bar_sum = bar_sum - 32'(H_ACTIVE);
    end
    case (state)
      IDLE: begin
        if (enable) begin
          nxt_state = STREAM;
          nxt_mode  = mode;
          nxt_x     = '0;
          nxt_y     = '0;
        end
      end
      default: begin
        if (xfer) begin
          if (eol) begin
            nxt_x = '0;
            if (eof) begin
              nxt_y   = '0;
              nxt_bar = XW'(bar_sum);
              // Back-to-back frames: relatch mode with no gap, or stop cleanly.
              if (enable) begin
                nxt_mode = mode;
              end else begin
                nxt_state = IDLE;
              end
            end else begin
              nxt_y = y + YW'(1);
            end
          end else begin
            nxt_x = x + XW'(1);
          end
        end
      end
    endcase
  end

  // State registers; stream outputs are registered from the next-state values,
  // so they change only on a transfer and never combinationally follow tready.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      bar_pos       <= '0;
      mode_q        <= 2'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 16'h0000;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      state         <= nxt_state;
      x             <= nxt_x;
      y             <= nxt_y;
      bar_pos       <= nxt_bar;
      mode_q        <= nxt_mode;
      m_axis_tvalid <= (nxt_state == STREAM);
      m_axis_tdata  <= (nxt_state == STREAM) ? pixel(nxt_x, nxt_y, nxt_mode, nxt_bar) : 16'h0000;
      m_axis_tuser  <= (nxt_state == STREAM) && (nxt_x == '0) && (nxt_y == '0);
      m_axis_tlast  <= (nxt_state == STREAM) && (nxt_x == XW'(H_ACTIVE - 1));
      frame_done    <= xfer && eof;
      if (xfer && eof) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_axis_pattern_gen.sv
// Bench for vga_axis_pattern_gen with a 16x4 frame: expected beats are queued as
// frames are requested and compared as the DUT transfers them.
module tb_vga_axis_pattern_gen;

  localparam int H    = 16;
  localparam int V    = 4;
  localparam int STEP = 8;
  localparam int FB   = H * V;

  logic        axi_clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        frame_done;
  logic [7:0]  frame_count;

  int          checks = 0;
  int          errors = 0;
  int          beats = 0;
  int          cyc = 0;
  int          tb_bar = 0;
  logic [7:0]  exp_fc = 8'd0;
  logic        pend_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] held = '0;
  logic [18:0] mon_e;
  logic [18:0] sb[$];

  always #5 axi_clk = ~axi_clk;

  vga_axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_STEP(STEP)) dut (
    .axi_clk(axi_clk),
    .axi_rstn(axi_rstn),
    .enable(enable),
    .mode(mode),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int px, input int py, input int pm, input int pb);
    logic [4:0] r;
    logic [5:0] g;
    case (pm)
      0: begin
        case (px / (H / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: begin
        r = px[7:3];
        g = py[7:2];
        return {r, g, ~r};
      end
      2: return (((px / 32) % 2) != ((py / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: return (px >= pb && px < pb + 16) ? 16'hFFFF : 16'h001F;
    endcase
  endfunction

  // Queue one full frame: {end_of_frame, tuser, tlast, tdata} per beat.
  task automatic push_frame(input int m);
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        sb.push_back({(xx == H - 1 && yy == V - 1), (xx == 0 && yy == 0), (xx == H - 1),
                      model_pix(xx, yy, m, tb_bar)});
      end
    end
    tb_bar = (tb_bar + STEP >= H) ? tb_bar + STEP - H : tb_bar + STEP;
  endtask

  task automatic wait_beats(input int n, input bit rnd);
    int g;
    int lim;
    g = 0;
    lim = 4 * (n - beats) + 100;
    while (beats < n && g < lim) begin
      @(posedge axi_clk);
      #1;
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      g++;
    end
    if (beats < n) chk("timeout", 32'(beats), 32'(n));
  endtask

  task automatic idle_check(input string tag);
    m_axis_tready = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    chk({tag, "_idle_tvalid"}, 32'(m_axis_tvalid), 0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  // Monitor: frame_done/frame_count model, hold-stability and scoreboard pops.
  initial begin
    forever begin
      @(negedge axi_clk);
      cyc++;
      if (!axi_rstn) begin
        pend_last  = 1'b0;
        exp_fc     = 8'd0;
        prev_stall = 1'b0;
      end else begin
        chk("frame_done", 32'(frame_done), 32'(pend_last));
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        if (prev_stall && m_axis_tvalid)
          chk("hold", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(held));
        pend_last = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          beats++;
          if (sb.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            chk($sformatf("beat%0d", beats), 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                32'(mon_e[17:0]));
            if (mon_e[18]) begin
              pend_last = 1'b1;
              exp_fc    = exp_fc + 8'd1;
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        held       = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    int base;
    int c0, b0;

    // Reset values
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tuser", 32'(m_axis_tuser), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_fd", 32'(frame_done), 0);
    axi_rstn = 1'b1;
    @(posedge axi_clk);
    #1;

    // Single colour-bar frame with full throughput
    base = beats;
    mode = 2'd0;
    push_frame(0);
    enable = 1'b1;
    wait_beats(base + 2, 1'b0);
    enable = 1'b0;
    wait_beats(base + FB, 1'b0);
    idle_check("bars");
    chk("bars_fc", 32'(frame_count), 1);

    // Two gradient/checker frames under random backpressure, mode changed mid-frame
    base = beats;
    mode = 2'd1;
    push_frame(1);
    push_frame(2);
    enable = 1'b1;
    wait_beats(base + 5, 1'b1);
    mode = 2'd2;
    wait_beats(base + FB + 5, 1'b1);
    enable = 1'b0;
    wait_beats(base + 2 * FB, 1'b1);
    idle_check("bp");

    // enable dropped at beat 10 and mode changed at beat 20: frame still completes
    base = beats;
    mode = 2'd1;
    push_frame(1);
    enable = 1'b1;
    wait_beats(base + 10, 1'b0);
    enable = 1'b0;
    wait_beats(base + 20, 1'b0);
    mode = 2'd3;
    wait_beats(base + FB, 1'b0);
    idle_check("endrop");

    // mode changed at beat 20 with enable held: new mode starts at next frame
    base = beats;
    mode = 2'd2;
    push_frame(2);
    push_frame(0);
    enable = 1'b1;
    wait_beats(base + 20, 1'b0);
    mode = 2'd0;
    wait_beats(base + FB + 3, 1'b0);
    enable = 1'b0;
    wait_beats(base + 2 * FB, 1'b0);
    idle_check("modechg");
    chk("modechg_fc", 32'(frame_count), 6);

    // Moving bar over four frames (bar_pos 0,8,0,8)
    base = beats;
    mode = 2'd3;
    chk("mbar_start", 32'(tb_bar), 0);
    repeat (4) push_frame(3);
    enable = 1'b1;
    wait_beats(base + 3 * FB + 3, 1'b0);
    enable = 1'b0;
    wait_beats(base + 4 * FB, 1'b0);
    idle_check("mbar");
    chk("mbar_fc", 32'(frame_count), 10);

    // Reset mid-frame at beat 30
    base = beats;
    mode = 2'd0;
    push_frame(0);
    enable = 1'b1;
    wait_beats(base + 30, 1'b0);
    axi_rstn = 1'b0;
    #1;
    chk("mrst_tvalid", 32'(m_axis_tvalid), 0);
    chk("mrst_tuser", 32'(m_axis_tuser), 0);
    chk("mrst_tlast", 32'(m_axis_tlast), 0);
    chk("mrst_tdata", 32'(m_axis_tdata), 0);
    chk("mrst_fc", 32'(frame_count), 0);
    sb.delete();
    tb_bar = 0;
    push_frame(0);
    repeat (2) @(posedge axi_clk);
    #1;
    axi_rstn = 1'b1;
    base = beats;
    wait_beats(base + 3, 1'b0);
    enable = 1'b0;
    wait_beats(base + FB, 1'b0);
    idle_check("mrst");
    chk("mrst_fc_after", 32'(frame_count), 1);

    // 300 back-to-back frames: frame_count wraps and no gap cycles appear
    base = beats;
    mode = 2'd1;
    repeat (300) push_frame(1);
    enable = 1'b1;
    wait_beats(base + 1, 1'b0);
    c0 = cyc;
    b0 = beats;
    wait_beats(base + 299 * FB + 2, 1'b0);
    enable = 1'b0;
    wait_beats(base + 300 * FB, 1'b0);
    chk("no_gap", 32'(cyc - c0), 32'(beats - b0));
    idle_check("long");
    chk("wrap_fc", 32'(frame_count), 45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
